// File: rtl/fpu_pkg.sv
// Shared FPU opcode definitions and the opcode legality check.
// Pure definitions: no latency, no backpressure.
// Backpressure: not applicable.
package fpu_pkg;

    localparam int FPU_OP_W = 4;

    typedef enum logic [FPU_OP_W-1:0] {
        FP_ADD   = 4'b0000,
        FP_SUB   = 4'b0001,
        FP_MAX   = 4'b0010,
        FP_MUL   = 4'b0011,
        FP_MIN   = 4'b0100,
        FP_ABS   = 4'b0101,
        FP_NEG   = 4'b0110,
        FP_FLOOR = 4'b1000,
        FP_CEIL  = 4'b1001,
        FP_SIGN  = 4'b1010
    } fpu_op_e;

    function automatic logic fp_op_legal(input logic [FPU_OP_W-1:0] op);
        logic legal;
        case (op)
            FP_ADD, FP_SUB, FP_MAX, FP_MUL, FP_MIN,
            FP_ABS, FP_NEG, FP_FLOOR, FP_CEIL, FP_SIGN: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/fp_issue_fifo.sv
// Register-based synchronous FIFO exposing head data and occupancy.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the caller guarantees no push when full, pops on empty are ignored.
module fp_issue_fifo #(
    parameter int DAT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DAT_W-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [DAT_W-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DAT_W-1:0] mem_q [DEPTH];
    logic [DAT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fpu_issue.sv
// Issue front end for the combinational fpu: register request, capture result, return tagged responses in order.
// Latency: accepted at edge N, response valid after edge N+1; one op per cycle. Optional FP_ISSUE_STATS_EN adds counters.
// Backpressure: req_ready_o is credit-based on FIFO occupancy plus the in-flight op; no path from rsp_ready_i.
module fpu_issue
    import fpu_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [FPU_OP_W-1:0]  req_op_i,
    input  logic [WIDTH-1:0]     req_a_i,
    input  logic [WIDTH-1:0]     req_b_i,
    input  logic [TAG_W-1:0]     req_tag_i,
    output logic [WIDTH-1:0]     fpu_a_o,
    output logic [WIDTH-1:0]     fpu_b_o,
    output logic [FPU_OP_W-1:0]  fpu_ctrl_o,
    input  logic [WIDTH-1:0]     fpu_result_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [WIDTH-1:0]     rsp_result_o,
    output logic [TAG_W-1:0]     rsp_tag_o,
    output logic                 rsp_illegal_o,
    output logic                 busy_o
`ifdef FP_ISSUE_STATS_EN
    ,
    output logic [15:0]          ops_issued_o,
    output logic [15:0]          illegal_ops_o
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } rsp_ent_t;

    logic                iss_v_q,   iss_v_d;
    logic [WIDTH-1:0]    iss_a_q,   iss_a_d;
    logic [WIDTH-1:0]    iss_b_q,   iss_b_d;
    logic [FPU_OP_W-1:0] iss_op_q,  iss_op_d;
    logic [TAG_W-1:0]    iss_tag_q, iss_tag_d;
    logic                iss_ill_q, iss_ill_d;

    logic [CNT_W-1:0]    rsp_count;
    logic [CNT_W:0]      credit_used;
    logic                accept;
    logic                pop;
    rsp_ent_t            push_ent;
    rsp_ent_t            head_ent;

    // Counting the in-flight op against the FIFO guarantees its push always finds room.
    assign credit_used = {1'b0, rsp_count} + (CNT_W+1)'(iss_v_q);
    assign req_ready_o = credit_used < (CNT_W+1)'(DEPTH);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        iss_a_d   = iss_a_q;
        iss_b_d   = iss_b_q;
        iss_op_d  = iss_op_q;
        iss_tag_d = iss_tag_q;
        iss_ill_d = iss_ill_q;
        iss_v_d   = accept;
        if (accept) begin
            iss_a_d   = req_a_i;
            iss_b_d   = req_b_i;
            iss_op_d  = req_op_i;
            iss_tag_d = req_tag_i;
            iss_ill_d = !fp_op_legal(req_op_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iss_v_q   <= 1'b0;
            iss_a_q   <= '0;
            iss_b_q   <= '0;
            iss_op_q  <= '0;
            iss_tag_q <= '0;
            iss_ill_q <= 1'b0;
        end else begin
            iss_v_q   <= iss_v_d;
            iss_a_q   <= iss_a_d;
            iss_b_q   <= iss_b_d;
            iss_op_q  <= iss_op_d;
            iss_tag_q <= iss_tag_d;
            iss_ill_q <= iss_ill_d;
        end
    end

    assign fpu_a_o    = iss_a_q;
    assign fpu_b_o    = iss_b_q;
    assign fpu_ctrl_o = iss_op_q;

    assign push_ent.result  = iss_ill_q ? '0 : fpu_result_i;
    assign push_ent.tag     = iss_tag_q;
    assign push_ent.illegal = iss_ill_q;

    fp_issue_fifo #(
        .DAT_W ($bits(rsp_ent_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (iss_v_q),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .head_dat_o (head_ent),
        .count_o    (rsp_count)
    );

    assign rsp_valid_o   = (rsp_count != '0);
    assign pop           = rsp_valid_o && rsp_ready_i;
    assign rsp_result_o  = rsp_valid_o ? head_ent.result  : '0;
    assign rsp_tag_o     = rsp_valid_o ? head_ent.tag     : '0;
    assign rsp_illegal_o = rsp_valid_o ? head_ent.illegal : 1'b0;
    assign busy_o        = iss_v_q || rsp_valid_o;

`ifdef FP_ISSUE_STATS_EN
    logic [15:0] ops_q, ops_d;
    logic [15:0] ill_q, ill_d;

    always_comb begin
        ops_d = ops_q;
        ill_d = ill_q;
        if (accept && ops_q != 16'hFFFF) begin
            ops_d = ops_q + 16'd1;
        end
        if (accept && !fp_op_legal(req_op_i) && ill_q != 16'hFFFF) begin
            ill_d = ill_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ops_q <= '0;
            ill_q <= '0;
        end else begin
            ops_q <= ops_d;
            ill_q <= ill_d;
        end
    end

    assign ops_issued_o  = ops_q;
    assign illegal_ops_o = ill_q;
`endif

endmodule
